// File: rtl/drec_multitrack_ctrl.sv
// drec_multitrack_ctrl: multi-track SDRAM sample recorder/player with per-track length memory and loop playback.
module drec_multitrack_ctrl #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 24,
  parameter int TRK_W        = 2,
  parameter int TRACK_ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              ctl_rec,
  input  logic              ctl_play,
  input  logic              ctl_stop,
  input  logic              ctl_loop,
  input  logic [TRK_W-1:0]  ctl_track,
  output logic              ctl_ack,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_enable,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [DATA_W-1:0] sdram_wr_data,
  output logic              sdram_wr_enable,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic              sdram_rd_enable,
  input  logic [DATA_W-1:0] sdram_rd_data,
  input  logic              sdram_rd_data_rdy,
  output logic              sdram_rd_data_ack,
  output logic              busy,
  output logic              underrun
);
  localparam int TRACKS = 2**TRK_W;
  localparam int TA = TRACK_ADDR_W;
  localparam logic [TA:0] LAST = (TA+1)'(2**TA - 1);
  localparam logic [TA:0] FULL = (TA+1)'(2**TA);
  typedef enum logic [1:0] {IDLE, REC, PLAY_ISSUE, PLAY_WAIT} state_t;
  state_t            r_state;
  logic [TA:0]       r_ptr;
  logic [TA:0]       r_len [TRACKS];
  logic [TRK_W-1:0]  r_trk;
  logic              r_loop;
  logic [TA:0]       w_ptr_inc;
  logic [ADDR_W-1:0] w_addr;
  logic              w_rd_vld;
  assign w_ptr_inc = r_ptr + (TA+1)'(1);
  assign w_addr    = ADDR_W'({r_trk, r_ptr[TA-1:0]});
  // The head word is still visible during its own pop cycle; don't count it twice.
  assign w_rd_vld  = sdram_rd_data_rdy && !sdram_rd_data_ack;
  assign busy      = r_state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state           <= IDLE;
      r_ptr             <= '0;
      r_trk             <= '0;
      r_loop            <= 1'b0;
      for (int i = 0; i < TRACKS; i++) r_len[i] <= '0;
      ctl_ack           <= 1'b0;
      dac_data          <= '0;
      dac_enable        <= 1'b0;
      sdram_wr_addr     <= '0;
      sdram_wr_data     <= '0;
      sdram_wr_enable   <= 1'b0;
      sdram_rd_addr     <= '0;
      sdram_rd_enable   <= 1'b0;
      sdram_rd_data_ack <= 1'b0;
      underrun          <= 1'b0;
    end else begin
      ctl_ack           <= 1'b0;
      dac_enable        <= 1'b0;
      sdram_wr_enable   <= 1'b0;
      sdram_rd_enable   <= 1'b0;
      sdram_rd_data_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          sdram_rd_data_ack <= w_rd_vld;
          if (ctl_stop) ctl_ack <= 1'b1;
          else if (ctl_rec || ctl_play) begin
            ctl_ack  <= 1'b1;
            underrun <= 1'b0;
            r_trk    <= ctl_track;
            r_loop   <= ctl_loop;
            r_ptr    <= '0;
            r_state  <= ctl_rec ? REC : (r_len[ctl_track] != '0 ? PLAY_ISSUE : IDLE);
          end
        end
        REC: begin
          sdram_rd_data_ack <= w_rd_vld;
          if (ctl_stop) begin
            ctl_ack       <= 1'b1;
            r_len[r_trk]  <= r_ptr;
            r_state       <= IDLE;
          end else if (sample_tick) begin
            sdram_wr_enable <= 1'b1;
            sdram_wr_addr   <= w_addr;
            sdram_wr_data   <= adc_data;
            r_ptr           <= w_ptr_inc;
            if (r_ptr == LAST) begin
              r_len[r_trk] <= FULL;
              r_state      <= IDLE;
            end
          end
        end
        PLAY_ISSUE: begin
          if (ctl_stop) begin
            ctl_ack <= 1'b1;
            r_state <= IDLE;
          end else if (sample_tick) begin
            sdram_rd_enable <= 1'b1;
            sdram_rd_addr   <= w_addr;
            r_state         <= PLAY_WAIT;
          end
        end
        default: begin
          if (ctl_stop) begin
            ctl_ack <= 1'b1;
            r_state <= IDLE;
          end else if (w_rd_vld) begin
            dac_data          <= sdram_rd_data;
            dac_enable        <= 1'b1;
            sdram_rd_data_ack <= 1'b1;
            r_ptr             <= (w_ptr_inc == r_len[r_trk]) ? '0 : w_ptr_inc;
            r_state           <= (w_ptr_inc == r_len[r_trk] && !r_loop) ? IDLE : PLAY_ISSUE;
          end else if (sample_tick) underrun <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_drec_multitrack_ctrl.sv
// tb_drec_multitrack_ctrl: randomized scenario bench with a track-memory reference model and a fake SDRAM read FIFO.
module tb_drec_multitrack_ctrl;
  localparam int DW = 16, AW = 24, TW = 2, TA = 20, STA = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, sample_tick = 1'b0, ctl_rec = 1'b0, ctl_play = 1'b0, ctl_stop = 1'b0, ctl_loop = 1'b0;
  logic [DW-1:0] adc_data = '0, rd_data = '0, dac_data, wr_data;
  logic [TW-1:0] ctl_track = '0;
  logic [AW-1:0] wr_addr, rd_addr;
  logic ctl_ack, dac_enable, wr_en, rd_en, rd_rdy = 1'b0, rd_ack, busy, underrun;
  logic s_tick = 1'b0, s_rec = 1'b0, s_play = 1'b0;
  logic [DW-1:0] s_adc = '0, s_dac_data, s_wr_data;
  logic [TW-1:0] s_track = '0;
  logic [AW-1:0] s_wr_addr, s_rd_addr;
  logic s_ack, s_dac_en, s_wr_en, s_rd_en, s_rd_ack, s_busy, s_underrun;

  drec_multitrack_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TRK_W(TW), .TRACK_ADDR_W(TA)) u_dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .adc_data(adc_data),
    .ctl_rec(ctl_rec), .ctl_play(ctl_play), .ctl_stop(ctl_stop), .ctl_loop(ctl_loop), .ctl_track(ctl_track),
    .ctl_ack(ctl_ack), .dac_data(dac_data), .dac_enable(dac_enable),
    .sdram_wr_addr(wr_addr), .sdram_wr_data(wr_data), .sdram_wr_enable(wr_en),
    .sdram_rd_addr(rd_addr), .sdram_rd_enable(rd_en), .sdram_rd_data(rd_data),
    .sdram_rd_data_rdy(rd_rdy), .sdram_rd_data_ack(rd_ack), .busy(busy), .underrun(underrun));

  drec_multitrack_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TRK_W(TW), .TRACK_ADDR_W(STA)) u_small (
    .clk(clk), .rst_n(rst_n), .sample_tick(s_tick), .adc_data(s_adc),
    .ctl_rec(s_rec), .ctl_play(s_play), .ctl_stop(1'b0), .ctl_loop(1'b0), .ctl_track(s_track),
    .ctl_ack(s_ack), .dac_data(s_dac_data), .dac_enable(s_dac_en),
    .sdram_wr_addr(s_wr_addr), .sdram_wr_data(s_wr_data), .sdram_wr_enable(s_wr_en),
    .sdram_rd_addr(s_rd_addr), .sdram_rd_enable(s_rd_en), .sdram_rd_data(16'h5a5a),
    .sdram_rd_data_rdy(1'b1), .sdram_rd_data_ack(s_rd_ack), .busy(s_busy), .underrun(s_underrun));

  int checks = 0, errors = 0;
  int model_len [4];
  logic [DW-1:0] model_mem [4][16];
  logic [DW-1:0] sdram [logic [AW-1:0]];
  logic [AW-1:0] wr_a_q[$], rd_q[$], s_wr_a_q[$];
  logic [DW-1:0] wr_d_q[$], dac_q[$], s_wr_d_q[$];
  int ack_cnt = 0, s_dac_cnt = 0, s_rd_cnt = 0, reply_dly = 3, resp_to = 0;

  function automatic logic [AW-1:0] ea(input int t, input int o, input int aw);
    return AW'(t * (1 << aw) + o);
  endfunction

  always @(negedge clk) begin
    if (wr_en) begin
      wr_a_q.push_back(wr_addr);
      wr_d_q.push_back(wr_data);
      sdram[wr_addr] = wr_data;
    end
    if (rd_en) rd_q.push_back(rd_addr);
    if (dac_enable) dac_q.push_back(dac_data);
    if (ctl_ack) ack_cnt++;
    if (s_wr_en) begin
      s_wr_a_q.push_back(s_wr_addr);
      s_wr_d_q.push_back(s_wr_data);
    end
    if (s_dac_en) s_dac_cnt++;
    if (s_rd_en) s_rd_cnt++;
  end

  // Read-data FIFO stand-in: answers each read after reply_dly cycles and holds the word until popped.
  initial begin
    logic [AW-1:0] a;
    int w;
    forever begin
      @(negedge clk);
      if (rd_en) begin
        a = rd_addr;
        repeat (reply_dly) @(negedge clk);
        rd_data = sdram.exists(a) ? sdram[a] : '0;
        rd_rdy = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (!rd_ack && w < 50);
        if (!rd_ack) resp_to++;
        @(posedge clk);
        #1 rd_rdy = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic cmd(input logic rec, input logic play, input logic stop, input logic [TW-1:0] trk, input logic lp);
    ctl_rec = rec; ctl_play = play; ctl_stop = stop; ctl_track = trk; ctl_loop = lp;
    @(negedge clk);
    ctl_rec = 1'b0; ctl_play = 1'b0; ctl_stop = 1'b0;
  endtask

  task automatic clear_mon();
    wr_a_q.delete(); wr_d_q.delete(); rd_q.delete(); dac_q.delete();
    ack_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++; if ({busy, underrun} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {busy, underrun}); end
    checks++; if ({ctl_ack, dac_enable, wr_en, rd_en, rd_ack} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 00000", {ctl_ack, dac_enable, wr_en, rd_en, rd_ack}); end
    checks++; if ({wr_addr, rd_addr, wr_data, dac_data} !== '0) begin errors++; $display("FAIL reset_buses: got %h expected 0", {wr_addr, rd_addr, wr_data, dac_data}); end
    rst_n = 1'b1;
    idle(2);
    for (int t = 0; t < 4; t++) model_len[t] = 0;
  endtask

  task automatic test_record();
    int rt, n;
    clear_mon();
    cmd(1, 0, 0, 2, 0);
    for (int i = 0; i < 5; i++) begin
      adc_data = DW'(i + 1);
      model_mem[2][i] = DW'(i + 1);
      tick();
      idle(2);
    end
    cmd(0, 0, 1, 0, 0);
    idle(2);
    model_len[2] = 5;
    checks++; if (ack_cnt !== 2) begin errors++; $display("FAIL rec_acks: got %0d expected 2", ack_cnt); end
    checks++; if (wr_a_q.size() !== 5) begin errors++; $display("FAIL rec_wr_count: got %0d expected 5", wr_a_q.size()); end
    for (int i = 0; i < 5 && i < wr_a_q.size(); i++) begin
      checks++; if (wr_a_q[i] !== ea(2, i, TA) || wr_d_q[i] !== model_mem[2][i]) begin errors++; $display("FAIL rec_wr[%0d]: got %h/%h expected %h/%h", i, wr_a_q[i], wr_d_q[i], ea(2, i, TA), model_mem[2][i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rec_idle: busy %b expected 0", busy); end
    // Back-to-back ticks on a random track; the final tick coincides with stop and must not write.
    clear_mon();
    rt = $urandom_range(0, 1);
    n = $urandom_range(3, 12);
    cmd(1, 0, 0, TW'(rt), 0);
    for (int i = 0; i < n; i++) begin
      adc_data = DW'($urandom);
      model_mem[rt][i] = adc_data;
      tick();
    end
    adc_data = DW'($urandom);
    ctl_stop = 1'b1; sample_tick = 1'b1;
    @(negedge clk);
    ctl_stop = 1'b0; sample_tick = 1'b0;
    idle(2);
    model_len[rt] = n;
    checks++; if (wr_a_q.size() !== n) begin errors++; $display("FAIL rec_stop_tick_count: got %0d expected %0d", wr_a_q.size(), n); end
    for (int i = 0; i < n && i < wr_a_q.size(); i++) begin
      checks++; if (wr_a_q[i] !== ea(rt, i, TA) || wr_d_q[i] !== model_mem[rt][i]) begin errors++; $display("FAIL rec_b2b[%0d]: got %h/%h expected %h/%h", i, wr_a_q[i], wr_d_q[i], ea(rt, i, TA), model_mem[rt][i]); end
    end
  endtask

  task automatic test_play(input int t);
    clear_mon();
    reply_dly = $urandom_range(1, 5);
    cmd(0, 1, 0, TW'(t), 0);
    for (int i = 0; i < model_len[t]; i++) begin
      tick();
      idle(7);
    end
    checks++; if (rd_q.size() !== model_len[t] || dac_q.size() !== model_len[t]) begin errors++; $display("FAIL play_count trk%0d: got %0d reads %0d dac expected %0d", t, rd_q.size(), dac_q.size(), model_len[t]); end
    for (int i = 0; i < model_len[t] && i < rd_q.size() && i < dac_q.size(); i++) begin
      checks++; if (rd_q[i] !== ea(t, i, TA) || dac_q[i] !== model_mem[t][i]) begin errors++; $display("FAIL play[%0d] trk%0d: got %h/%h expected %h/%h", i, t, rd_q[i], dac_q[i], ea(t, i, TA), model_mem[t][i]); end
    end
    checks++; if (busy !== 1'b0 || ack_cnt !== 1) begin errors++; $display("FAIL play_end trk%0d: busy %b acks %0d expected 0/1", t, busy, ack_cnt); end
  endtask

  task automatic test_loop();
    clear_mon();
    reply_dly = $urandom_range(1, 5);
    cmd(0, 1, 0, 2, 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      idle(7);
    end
    checks++; if (rd_q.size() !== 12 || dac_q.size() !== 12) begin errors++; $display("FAIL loop_count: got %0d reads %0d dac expected 12", rd_q.size(), dac_q.size()); end
    for (int i = 0; i < 12 && i < rd_q.size() && i < dac_q.size(); i++) begin
      checks++; if (rd_q[i] !== ea(2, i % 5, TA) || dac_q[i] !== model_mem[2][i % 5]) begin errors++; $display("FAIL loop[%0d]: got %h/%h expected %h/%h", i, rd_q[i], dac_q[i], ea(2, i % 5, TA), model_mem[2][i % 5]); end
    end
    checks++; if (underrun !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL loop_state: underrun %b busy %b expected 0/1", underrun, busy); end
    cmd(0, 0, 1, 0, 0);
    idle(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_stop: busy %b expected 0", busy); end
  endtask

  task automatic test_underrun();
    clear_mon();
    reply_dly = 14;
    cmd(0, 1, 0, 2, 0);
    tick();
    idle(7);
    tick();
    idle(12);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b expected 1", underrun); end
    checks++; if (rd_q.size() !== 1 || dac_q.size() !== 1 || busy !== 1'b1) begin errors++; $display("FAIL underrun_drop: %0d reads %0d dac busy %b expected 1/1/1", rd_q.size(), dac_q.size(), busy); end
    reply_dly = 3;
    cmd(0, 0, 1, 0, 0);
    idle(1);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b expected 1", underrun); end
    cmd(1, 0, 0, 3, 0);
    checks++; if (underrun !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL underrun_clear: underrun %b busy %b expected 0/1", underrun, busy); end
    cmd(0, 0, 1, 0, 0);
    idle(2);
    model_len[3] = 0;
  endtask

  task automatic test_stop_mid_play();
    clear_mon();
    resp_to = 0;
    reply_dly = 6;
    cmd(0, 1, 0, 2, 0);
    tick();
    idle(2);
    cmd(0, 0, 1, 0, 0);
    idle(14);
    checks++; if (rd_q.size() !== 1 || dac_q.size() !== 0) begin errors++; $display("FAIL stop_play: %0d reads %0d dac expected 1/0", rd_q.size(), dac_q.size()); end
    checks++; if (resp_to !== 0 || rd_rdy !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stop_discard: timeouts %0d rdy %b busy %b expected 0/0/0", resp_to, rd_rdy, busy); end
    reply_dly = 3;
  endtask

  task automatic test_empty_simul_reset();
    clear_mon();
    cmd(0, 1, 0, 3, 0);
    tick();
    idle(4);
    checks++; if (ack_cnt !== 1 || rd_q.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL empty_play: acks %0d reads %0d busy %b expected 1/0/0", ack_cnt, rd_q.size(), busy); end
    clear_mon();
    cmd(1, 1, 0, 3, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL simul_busy: got %b expected 1", busy); end
    adc_data = 16'h1234; tick();
    adc_data = 16'h5678; tick();
    idle(1);
    checks++; if (wr_a_q.size() !== 2 || rd_q.size() !== 0) begin errors++; $display("FAIL simul_rec_wins: %0d writes %0d reads expected 2/0", wr_a_q.size(), rd_q.size()); end
    else begin
      checks++; if (wr_a_q[1] !== ea(3, 1, TA) || wr_d_q[1] !== 16'h5678) begin errors++; $display("FAIL simul_wr: got %h/%h expected %h/5678", wr_a_q[1], wr_d_q[1], ea(3, 1, TA)); end
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({busy, underrun, ctl_ack, dac_enable, wr_en, rd_en, rd_ack} !== 7'b0) begin errors++; $display("FAIL midrec_reset_ctl: got %b expected 0000000", {busy, underrun, ctl_ack, dac_enable, wr_en, rd_en, rd_ack}); end
    checks++; if ({wr_addr, rd_addr, wr_data, dac_data} !== '0) begin errors++; $display("FAIL midrec_reset_bus: got %h expected 0", {wr_addr, rd_addr, wr_data, dac_data}); end
    for (int t = 0; t < 4; t++) model_len[t] = 0;
    idle(1);
    clear_mon();
    cmd(0, 1, 0, 2, 0);
    tick();
    idle(4);
    checks++; if (ack_cnt !== 1 || rd_q.size() !== 0 || busy !== 1'b0 || wr_a_q.size() !== 0) begin errors++; $display("FAIL len_cleared: acks %0d reads %0d writes %0d busy %b expected 1/0/0/0", ack_cnt, rd_q.size(), wr_a_q.size(), busy); end
  endtask

  task automatic test_full_track();
    int st;
    logic [DW-1:0] exp_d [8];
    st = $urandom_range(0, 3);
    s_wr_a_q.delete(); s_wr_d_q.delete();
    s_track = TW'(st);
    s_rec = 1'b1;
    @(negedge clk);
    s_rec = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_adc = DW'($urandom);
      if (i < 8) exp_d[i] = s_adc;
      s_tick = 1'b1;
      @(negedge clk);
    end
    s_tick = 1'b0;
    idle(2);
    checks++; if (s_wr_a_q.size() !== 8 || s_busy !== 1'b0) begin errors++; $display("FAIL full_auto_stop: %0d writes busy %b expected 8/0", s_wr_a_q.size(), s_busy); end
    for (int i = 0; i < 8 && i < s_wr_a_q.size(); i++) begin
      checks++; if (s_wr_a_q[i] !== ea(st, i, STA) || s_wr_d_q[i] !== exp_d[i]) begin errors++; $display("FAIL full_wr[%0d]: got %h/%h expected %h/%h", i, s_wr_a_q[i], s_wr_d_q[i], ea(st, i, STA), exp_d[i]); end
    end
    s_dac_cnt = 0; s_rd_cnt = 0;
    s_play = 1'b1;
    @(negedge clk);
    s_play = 1'b0;
    s_tick = 1'b1;
    idle(30);
    s_tick = 1'b0;
    idle(2);
    checks++; if (s_dac_cnt !== 8 || s_rd_cnt !== 8 || s_busy !== 1'b0) begin errors++; $display("FAIL full_len: %0d dac %0d reads busy %b expected 8/8/0", s_dac_cnt, s_rd_cnt, s_busy); end
  endtask

  initial begin
    test_reset();
    test_record();
    for (int t = 0; t < 3; t++) if (model_len[t] > 0) test_play(t);
    test_loop();
    test_underrun();
    test_stop_mid_play();
    test_empty_simul_reset();
    test_full_track();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/drec_multitrack_ctrl.md
Name: drec_multitrack_ctrl

Overview:
Parametrised successor to the single-track recorder controller. It records ADC samples into, and plays them back from, one of 2**TRK_W independent SDRAM track regions, with per-track length memory and optional loop playback. It sits in the clk1m1 domain between the button/ADC front end and the SDRAM write, read-address and read-data FIFOs. It paces samples from an external sample_tick strobe.

Parameters:
DATA_W, 16, sample width on the ADC, DAC and SDRAM data paths
ADDR_W, 24, SDRAM word address width
TRK_W, 2, track-select width; TRACKS = 2**TRK_W
TRACK_ADDR_W, 20, per-track offset width; a track holds at most 2**TRACK_ADDR_W samples; legal only when TRK_W+TRACK_ADDR_W <= ADDR_W

Ports:
clk  in  1  single clock (clk1m1 domain)
rst_n  in  1  reset, synchronous, active-low
sample_tick  in  1  one-cycle sample-rate strobe
adc_data  in  DATA_W  current ADC sample
ctl_rec  in  1  record request
ctl_play  in  1  play request
ctl_stop  in  1  stop request
ctl_loop  in  1  loop mode, sampled when play is accepted
ctl_track  in  TRK_W  track select, sampled when rec/play is accepted
ctl_ack  out  1  one-cycle pulse when a command is accepted
dac_data  out  DATA_W  playback sample
dac_enable  out  1  one-cycle strobe when dac_data is valid
sdram_wr_addr  out  ADDR_W  write address
sdram_wr_data  out  DATA_W  write data
sdram_wr_enable  out  1  one-cycle write push
sdram_rd_addr  out  ADDR_W  read address
sdram_rd_enable  out  1  one-cycle read-address push
sdram_rd_data  in  DATA_W  read-data FIFO head
sdram_rd_data_rdy  in  1  read-data FIFO non-empty
sdram_rd_data_ack  out  1  one-cycle pop of the read-data FIFO
busy  out  1  high when not in IDLE
underrun  out  1  sticky flag; cleared by reset or an accepted rec/play

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All outputs 0, including dac_data and both addresses. Pointer is 0. Every track length register is 0.
- Reset takes effect from any state. In-flight FIFO data is not the block's concern. After reset, any rd-data arriving in IDLE is popped (ack pulse) and discarded.
- Address = zero-extend({track, offset}) to ADDR_W.
- Per-track length register: TRACK_ADDR_W+1 bits, range 0..2**TRACK_ADDR_W.
- States: IDLE, REC, PLAY_ISSUE, PLAY_WAIT.
- IDLE:
  - Command priority is stop > rec > play.
  - stop: ctl_ack pulse, stays IDLE.
  - rec: ctl_ack pulse, latch track, pointer=0, go to REC.
  - play on a track with length 0: ctl_ack pulse, stays IDLE.
  - play on a track with length > 0: ctl_ack pulse, latch track and loop, pointer=0, go to PLAY_ISSUE.
- REC:
  - On sample_tick: sdram_wr_enable pulse with addr=ptr and data=adc_data (both registered, same cycle as the enable), then ptr++.
  - When the write at offset 2**TRACK_ADDR_W-1 issues: length = 2**TRACK_ADDR_W, go to IDLE.
  - ctl_stop: length = ptr (samples written so far), ctl_ack pulse, go to IDLE. If sample_tick arrives in the same cycle, stop wins and no write is issued.
  - rec/play requests are ignored (no ack).
- PLAY_ISSUE:
  - On sample_tick: sdram_rd_enable pulse with addr=ptr, go to PLAY_WAIT.
- PLAY_WAIT:
  - When sdram_rd_data_rdy=1: dac_data <= sdram_rd_data, and dac_enable and sdram_rd_data_ack pulse in the same cycle.
  - If ptr+1 == length: with loop, set ptr=0 and go to PLAY_ISSUE; without loop, go to IDLE.
  - Otherwise ptr++ and go to PLAY_ISSUE.
  - A sample_tick while in PLAY_WAIT sets underrun and the tick is dropped. A tick coinciding with rdy is not an underrun; it is consumed as the next issue only after the return to PLAY_ISSUE.
- ctl_stop in PLAY_ISSUE or PLAY_WAIT: ctl_ack pulse, go to IDLE. A pending read-data word is popped and discarded when it arrives, with no dac_enable.
- Every strobe output is exactly one cycle wide. There is at most one outstanding read.
- Pointer arithmetic is TRACK_ADDR_W+1 bits with no wrap beyond the length.

Test Plan:
- Reset, then rec on track 2, 5 sample_ticks with adc_data 1..5, then stop -> 5 write pulses to addresses 0x200000..0x200004 with data 1..5; ctl_ack pulses twice; track-2 length = 5.
- Play track 2, loop=0, reply to each read with its data after 3 cycles -> reads at 0x200000..0x200004; dac_data 1..5, each with a dac_enable pulse; then IDLE and busy=0.
- Play track 2 with loop=1, 12 ticks -> read addresses cycle offsets 0,1,2,3,4,0,1,...; no underrun.
- Play with the read reply delayed past the next sample_tick -> underrun=1 and that tick produces no read; a subsequent accepted rec clears underrun.
- TRACK_ADDR_W=3: rec with continuous ticks -> exactly 8 writes, auto-return to IDLE, length = 8.
- Play on an empty track, simultaneous rec+play, and rst_n low mid-REC -> ack with no reads; rec wins; all outputs 0, lengths 0, state IDLE on the next cycle.
